// File: rtl/sa_result_drain.sv
// sa_result_drain
// ----------------
// Drains the systolic core's per-column result buffers onto a single
// valid/ready stream. When every column reports valid, or when flush is
// raised with at least one column valid, the column words and the valid
// mask are captured into a local snapshot. The valid columns are then
// emitted in ascending index order, each word tagged with its column index,
// and m_last marks the final one. After the last transfer, rread pulses for
// one cycle so the core can release its buffers. The block then waits for
// the core to drop all of its valids before it re-arms.
//
// Ports
//   clk        clock
//   rstn       synchronous active-low reset
//   in_r       per-column result words from the core
//   in_v       per-column result-valid flags from the core (index 0 = column 0)
//   flush      force a drain of whichever columns are currently valid
//   rread      one-cycle pulse: buffered results have been consumed
//   m_data     streamed result word
//   m_col      column index of m_data
//   m_valid    stream word valid
//   m_last     final word of the current frame
//   m_ready    downstream accepts the word
//   busy       high in any state other than IDLE
//   frame_cnt  number of completed frames, wraps modulo 2^CNTW
module sa_result_drain #(
    parameter int ROWS     = 8,
    parameter int OUTWIDTH = 32,
    parameter int CNTW     = 16
) (
    input  logic                                    clk,
    input  logic                                    rstn,
    input  logic [OUTWIDTH-1:0]                     in_r [0:ROWS-1],
    input  logic [0:ROWS-1]                         in_v,
    input  logic                                    flush,
    output logic                                    rread,
    output logic [OUTWIDTH-1:0]                     m_data,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] m_col,
    output logic                                    m_valid,
    output logic                                    m_last,
    input  logic                                    m_ready,
    output logic                                    busy,
    output logic [CNTW-1:0]                         frame_cnt
);

    localparam int COLW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        ACK,
        WAIT_CLR
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [OUTWIDTH-1:0]   snap [0:ROWS-1];
    logic [0:ROWS-1]       mask;
    logic [COLW-1:0]       idx;
    logic [COLW-1:0]       next_idx;
    logic [COLW-1:0]       first_idx;
    logic                  has_next;
    logic                  trigger;

    // A flush with nothing valid would produce an empty frame, so it is
    // not treated as a trigger.
    assign trigger = (&in_v) || (flush && (|in_v));

    // Lowest valid column of the incoming frame. The loop runs downwards
    // so that the last hit, which wins, is the lowest index.
    always_comb begin
        first_idx = '0;
        for (int k = ROWS - 1; k >= 0; k--) begin
            if (in_v[k]) begin
                first_idx = COLW'(k);
            end
        end
    end

    // Next captured column above the current one. When none exists the
    // current word is the last of the frame.
    always_comb begin
        next_idx = idx;
        has_next = 1'b0;
        for (int k = ROWS - 1; k >= 0; k--) begin
            if (mask[k] && (COLW'(k) > idx)) begin
                next_idx = COLW'(k);
                has_next = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        m_data     = '0;
        m_col      = '0;
        rread      = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (trigger) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                m_valid = 1'b1;
                m_data  = snap[idx];
                m_col   = idx;
                m_last  = !has_next;
                if (m_ready && !has_next) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                rread      = 1'b1;
                state_next = WAIT_CLR;
            end
            WAIT_CLR: begin
                // Re-arming early would capture the frame just drained.
                if (in_v == '0) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The snapshot is written only on the trigger edge. This keeps the
    // in-flight frame isolated from whatever the core does during streaming.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            mask      <= '0;
            idx       <= '0;
            frame_cnt <= '0;
            for (int k = 0; k < ROWS; k++) begin
                snap[k] <= '0;
            end
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        mask <= in_v;
                        idx  <= first_idx;
                        for (int k = 0; k < ROWS; k++) begin
                            snap[k] <= in_r[k];
                        end
                    end
                end
                STREAM: begin
                    if (m_ready && has_next) begin
                        idx <= next_idx;
                    end
                end
                ACK: begin
                    frame_cnt <= frame_cnt + CNTW'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
